// File: rtl/ma_sram_ctrl_if.sv
// ma_sram_ctrl_if: memory-stage request bus plus 16-bit SRAM pins of the load/store bridge
interface ma_sram_ctrl_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;
  modport master (
    output wr_en, rd_en, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
  modport slave (
    input  wr_en, rd_en, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/ma_sram_ctrl.sv
// ma_sram_ctrl: 32-bit CPU load/store bridged onto a 16-bit SRAM as two timed half-accesses
module ma_sram_ctrl #(
  parameter int SRAM_WAIT = 2,
  parameter int BASE_ADDR = 1024
) (
  input logic clk,
  input logic rst,
  ma_sram_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
  localparam logic [2:0] LAST = 3'(SRAM_WAIT - 1);
  state_t      state;
  logic [2:0]  cnt;
  logic        op_wr;
  logic [16:0] word;
  logic [15:0] wdata_hi;
  logic [16:0] word_in;
  logic        req;
  assign req = bus.wr_en | bus.rd_en;
  assign word_in = 17'((bus.address - 32'(BASE_ADDR)) >> 2);
  assign bus.ready = (state == DONE) || (state == IDLE && !req);
  // SRAM pins are registered alongside the state so each phase presents clean, stable signals
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      op_wr <= 1'b0;
      word <= '0;
      wdata_hi <= '0;
      bus.read_data <= '0;
      bus.sram_addr <= '0;
      bus.sram_dq_out <= '0;
      bus.sram_dq_oe <= 1'b0;
      bus.sram_we_n <= 1'b1;
    end else begin
      case (state)
        IDLE: if (req) begin
          state <= LOW;
          cnt <= '0;
          op_wr <= bus.wr_en;
          word <= word_in;
          wdata_hi <= bus.write_data[31:16];
          bus.sram_addr <= {word_in, 1'b0};
          bus.sram_dq_out <= bus.wr_en ? bus.write_data[15:0] : 16'h0;
          bus.sram_dq_oe <= bus.wr_en;
          bus.sram_we_n <= ~bus.wr_en;
        end
        LOW: if (cnt == LAST) begin
          state <= HIGH;
          cnt <= '0;
          bus.sram_addr <= {word, 1'b1};
          bus.sram_dq_out <= op_wr ? wdata_hi : 16'h0;
          if (!op_wr) bus.read_data[15:0] <= bus.sram_dq_in;
        end else cnt <= cnt + 3'd1;
        HIGH: if (cnt == LAST) begin
          state <= DONE;
          cnt <= '0;
          bus.sram_addr <= '0;
          bus.sram_dq_out <= '0;
          bus.sram_dq_oe <= 1'b0;
          bus.sram_we_n <= 1'b1;
          if (!op_wr) bus.read_data[31:16] <= bus.sram_dq_in;
        end else cnt <= cnt + 3'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ma_sram_ctrl.sv
// tb_ma_sram_ctrl: random and directed loads/stores checked against a word-level memory model
module tb_ma_sram_ctrl;
  localparam int BASE = 1024;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  int errors = 0;
  int checks = 0;
  ma_sram_ctrl_if ia();
  ma_sram_ctrl_if ib();
  ma_sram_ctrl #(.SRAM_WAIT(2), .BASE_ADDR(BASE)) dut_a (.clk(clk), .rst(rst_a), .bus(ia));
  ma_sram_ctrl #(.SRAM_WAIT(1), .BASE_ADDR(BASE)) dut_b (.clk(clk), .rst(rst_b), .bus(ib));
  always #5 clk = ~clk;
  logic [15:0] mem_a [0:262143];
  logic [15:0] mem_b [0:262143];
  logic [15:0] ref_mem [int];
  logic [31:0] exp_rd;
  int run_a = 0;
  logic [17:0] last_a = '0;
  function automatic logic [15:0] init_val(int h, bit salt);
    return 16'(h * 13 + 7) ^ (salt ? 16'h3C5A : 16'hA5C3);
  endfunction
  function automatic logic [15:0] ref_rd(int h);
    return ref_mem.exists(h) ? ref_mem[h] : init_val(h, 1'b0);
  endfunction
  function automatic int half_of(logic [31:0] addr);
    return int'(((addr - 32'(BASE)) >> 2) & 32'h1FFFF) * 2;
  endfunction
  // SRAM commits a half only after its address and strobe were held for the full wait time
  always @(posedge clk) begin
    if (!ia.sram_we_n) begin
      run_a = (run_a > 0 && ia.sram_addr == last_a) ? run_a + 1 : 1;
      last_a = ia.sram_addr;
      if (run_a == 2) mem_a[ia.sram_addr] = ia.sram_dq_out;
    end else run_a = 0;
  end
  always @(negedge clk) begin
    ia.sram_dq_in = mem_a[ia.sram_addr];
    ib.sram_dq_in = mem_b[ib.sram_addr];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic xact(input logic wr, input logic rd, input logic [31:0] addr, input logic [31:0] data, input bit junk);
    int h, lat, wcnt, ocnt;
    bit seen;
    h = half_of(addr);
    @(negedge clk);
    ia.wr_en = wr; ia.rd_en = rd; ia.address = addr; ia.write_data = data;
    lat = 0; wcnt = 0; ocnt = 0; seen = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (junk) begin
        ia.address = $urandom; ia.write_data = $urandom; ia.wr_en = 1'($urandom); ia.rd_en = 1'b1;
      end
      if (!ia.sram_we_n) wcnt++;
      if (ia.sram_dq_oe) ocnt++;
      if (ia.ready) begin seen = 1'b1; lat = c; end
    end
    ia.wr_en = 1'b0; ia.rd_en = 1'b0;
    if (wr) begin
      ref_mem[h] = data[15:0];
      ref_mem[h + 1] = data[31:16];
    end else exp_rd = {ref_rd(h + 1), ref_rd(h)};
    check("latency", 32'(lat), 32'd5);
    check("we_n_low_cycles", 32'(wcnt), wr ? 32'd4 : 32'd0);
    check("oe_cycles", 32'(ocnt), wr ? 32'd4 : 32'd0);
    check("done_bus", {12'h0, ia.sram_dq_oe, ia.sram_we_n, ia.sram_addr}, 32'h0004_0000);
    check("read_data", ia.read_data, exp_rd);
    if (wr) begin
      check("mem_lo", {16'h0, mem_a[h]}, {16'h0, ref_rd(h)});
      check("mem_hi", {16'h0, mem_a[h + 1]}, {16'h0, ref_rd(h + 1)});
    end
  endtask
  initial begin
    logic [31:0] d, a;
    logic [6:0] pat;
    for (int i = 0; i < 262144; i++) begin
      mem_a[i] = init_val(i, 1'b0);
      mem_b[i] = init_val(i, 1'b1);
    end
    exp_rd = '0;
    ia.wr_en = 1'b0; ia.rd_en = 1'b0; ia.address = '0; ia.write_data = '0;
    ib.wr_en = 1'b0; ib.rd_en = 1'b0; ib.address = '0; ib.write_data = '0;
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'h0, ia.ready}, 32'd1);
    check("rst_read_data", ia.read_data, 32'h0);
    check("rst_we_n", {31'h0, ia.sram_we_n}, 32'd1);
    check("rst_oe", {31'h0, ia.sram_dq_oe}, 32'd0);
    check("rst_addr", {14'h0, ia.sram_addr}, 32'd0);
    xact(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 1'b0);
    check("hw2", {16'h0, mem_a[2]}, 32'h0000BEEF);
    check("hw3", {16'h0, mem_a[3]}, 32'h0000DEAD);
    xact(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
    check("rd_deadbeef", ia.read_data, 32'hDEADBEEF);
    @(negedge clk);
    check("after_done_idle", {31'h0, ia.ready}, 32'd1);
    xact(1'b1, 1'b1, 32'd1024, 32'h12345678, 1'b0);
    check("both_rd_kept", ia.read_data, 32'hDEADBEEF);
    check("both_hw0", {16'h0, mem_a[0]}, 32'h00005678);
    xact(1'b0, 1'b1, 32'd0, 32'h0, 1'b0);
    for (int n = 0; n < 60; n++) begin
      logic wr;
      a = 32'(BASE) + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = $urandom;
      wr = 1'($urandom_range(0, 1));
      xact(wr, wr ? 1'($urandom_range(0, 1)) : 1'b1, a, $urandom, 1'($urandom_range(0, 1)));
    end
    d = 32'hCAFE_F00D;
    @(negedge clk);
    ia.wr_en = 1'b1; ia.address = 32'd1024; ia.write_data = d;
    repeat (3) @(negedge clk);
    check("high_phase_addr", {14'h0, ia.sram_addr}, 32'd1);
    rst_a = 1'b1; ia.wr_en = 1'b0;
    @(negedge clk);
    ref_mem[0] = d[15:0];
    exp_rd = '0;
    check("abort_we_n", {31'h0, ia.sram_we_n}, 32'd1);
    check("abort_ready", {31'h0, ia.ready}, 32'd1);
    check("abort_read_data", ia.read_data, 32'h0);
    check("abort_addr", {14'h0, ia.sram_addr}, 32'd0);
    rst_a = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_hw0", {16'h0, mem_a[0]}, {16'h0, ref_rd(0)});
    check("abort_hw1", {16'h0, mem_a[1]}, {16'h0, ref_rd(1)});
    xact(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);
    @(negedge clk);
    ib.rd_en = 1'b1; ib.address = 32'(BASE + 4 * 5);
    pat = '0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      pat = {pat[5:0], ib.ready};
      if (c == 3) begin
        check("b2b_first", ib.read_data, {init_val(11, 1'b1), init_val(10, 1'b1)});
        ib.address = 32'(BASE + 4 * 9 + 2);
      end
      if (c == 7) check("b2b_second", ib.read_data, {init_val(19, 1'b1), init_val(18, 1'b1)});
    end
    ib.rd_en = 1'b0;
    check("b2b_ready_pattern", {25'h0, pat}, 32'b0010001);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ma_sram_ctrl.md
MA_SRAM_CTRL -- requirements
Module: ma_sram_ctrl

Interface
REQ-001 Parameter SRAM_WAIT, default 2: cycles per 16-bit SRAM half-access (legal 1..7).
REQ-002 Parameter BASE_ADDR, default 1024: CPU byte address mapped to SRAM word 0.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 wr_en  in  1  memory-stage store request.
REQ-006 rd_en  in  1  memory-stage load request.
REQ-007 address  in  32  CPU byte address (ALU result).
REQ-008 write_data  in  32  store data (Val_Rm).
REQ-009 read_data  out  32  load result, fed to the MEM/WB register as mem_read_value.
REQ-010 ready  out  1  access complete or no access; pipeline freeze = ~ready.
REQ-011 sram_addr  out  18  SRAM half-word address.
REQ-012 sram_dq_out  out  16  data driven to SRAM.
REQ-013 sram_dq_in  in  16  data returned by SRAM.
REQ-014 sram_dq_oe  out  1  high when sram_dq_out drives the bus.
REQ-015 sram_we_n  out  1  SRAM write strobe, active-low.

Function
REQ-016 States: IDLE, LOW, HIGH, DONE; wait counter cnt, 3 bits.
REQ-017 offset = address - BASE_ADDR, 32-bit wraparound; word index w = offset[18:2]; offset[1:0] ignored.
REQ-018 LOW phase: sram_addr = {w,1'b0}; HIGH phase: sram_addr = {w,1'b1}; IDLE/DONE: sram_addr = 0.
REQ-019 IDLE: if wr_en|rd_en -> LOW, cnt=0; else stay. Op latched at this edge; wr_en wins when both high.
REQ-020 LOW: cnt increments each cycle; when cnt==SRAM_WAIT-1 -> HIGH, cnt=0.
REQ-021 HIGH: same count rule; when cnt==SRAM_WAIT-1 -> DONE.
REQ-022 DONE: unconditional -> IDLE next cycle.
REQ-023 ready = 1 in DONE; in IDLE, ready = ~(wr_en|rd_en) (combinational); 0 in LOW and HIGH.
REQ-024 Access latency: request at cycle 0 (IDLE) -> ready high at cycle 2*SRAM_WAIT+1; 2*SRAM_WAIT+1 freeze cycles.
REQ-025 Write: during LOW and HIGH, sram_we_n=0, sram_dq_oe=1; sram_dq_out = write_data[15:0] in LOW, write_data[31:16] in HIGH.
REQ-026 Read: sram_we_n=1, sram_dq_oe=0; read_data[15:0] captures sram_dq_in on last LOW cycle, read_data[31:16] on last HIGH cycle.
REQ-027 read_data holds its value through DONE and afterwards until the next read overwrites it; writes do not modify it.
REQ-028 IDLE/DONE: sram_we_n=1, sram_dq_oe=0, sram_dq_out=0.
REQ-029 Request inputs are held stable by upstream while ready=0; changes mid-access are ignored (latched op, address and data used).
REQ-030 Request still asserted in the cycle after DONE starts a new access (back-to-back); one IDLE cycle between accesses.

Reset
REQ-031 rst high at an edge: state=IDLE, cnt=0, read_data=0, latched op/address/data=0, regardless of state.
REQ-032 While in reset and after: sram_we_n=1, sram_dq_oe=0, sram_dq_out=0, sram_addr=0; ready follows REQ-023 IDLE rule.
REQ-033 Reset mid-write aborts it: we_n deasserts at the reset edge; no further SRAM half is written.

Verification
REQ-034 Reset then idle, no request -> ready=1, read_data=0, sram_we_n=1, sram_dq_oe=0.
REQ-035 SRAM_WAIT=2, wr_en, address=1028, write_data=0xDEADBEEF -> half-word 2 gets 0xBEEF, half-word 3 gets 0xDEAD, ready high at cycle 5, we_n low for exactly 4 cycles.
REQ-036 Then rd_en, address=1028, SRAM model returns stored halves -> read_data=0xDEADBEEF at cycle 5, ready=1 only in that cycle.
REQ-037 rd_en and wr_en both high, address=1024, write_data=0x12345678 -> write performed, read_data unchanged.
REQ-038 rst asserted during HIGH of a write -> IDLE next cycle, half-word 1 never written, read_data=0.
REQ-039 rd_en held across two accesses, SRAM_WAIT=1 -> ready pattern 0,0,1,0,0,0,1, second result matches the second address.
